// File: rtl/fft_pkg.sv
// Shared definitions for the streaming radix-2 FFT/IFFT blocks.
// Contents: default component width, complex pack/unpack macros, FSM state encoding.
// Complex words are {re, im}. re is the upper half and im is the lower half. Both are two's complement.

`ifndef FFT_PKG_MACROS
`define FFT_PKG_MACROS
`define FFT_RE(d, w) d[2*(w)-1:(w)]
`define FFT_IM(d, w) d[(w)-1:0]
`define FFT_PACK(re, im) {re, im}
`endif

package fft_pkg;

   localparam int FFT_W = 4;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      S1      = 2'd1,
      S2      = 2'd2,
      DRAIN   = 2'd3
   } fft_state_t;

endpackage

// File: rtl/ifft_bfly2.sv
// Combinational radix-2 inverse butterfly: sum=(a+b')>>>1, diff=(a-b')>>>1, b' = rot_j ? j*b : b.
// Latency: 0 cycles (pure combinational). Backpressure: none, the caller registers the results.
// Ports: a, b (2W complex words), rot_j (apply +j to b), sum, diff (2W complex words).

module ifft_bfly2 import fft_pkg::*; #(
   parameter int W = FFT_W
) (
   input  logic [2*W-1:0] a,
   input  logic [2*W-1:0] b,
   input  logic           rot_j,
   output logic [2*W-1:0] sum,
   output logic [2*W-1:0] diff
);

   logic signed [W:0] ar, ai, br, bi;
   logic signed [W:0] bpr, bpi;
   logic signed [W:0] sr, si, dr, di;
   logic              unused_lsb;

   always_comb begin
      // Sign-extend to W+1 bits. Every add, subtract and negation below then fits without overflow.
      ar = {a[2*W-1], `FFT_RE(a, W)};
      ai = {a[W-1],   `FFT_IM(a, W)};
      br = {b[2*W-1], `FFT_RE(b, W)};
      bi = {b[W-1],   `FFT_IM(b, W)};
      // j*b = (-b.im, b.re). Negating in W+1 bits keeps -2^(W-1) representable.
      bpr = rot_j ? -bi : br;
      bpi = rot_j ?  br : bi;
      sr  = ar + bpr;
      si  = ai + bpi;
      dr  = ar - bpr;
      di  = ai - bpi;
   end

   // Dropping the LSB of the W+1-bit result is an arithmetic shift right by 1 (floor).
   assign sum  = `FFT_PACK(sr[W:1], si[W:1]);
   assign diff = `FFT_PACK(dr[W:1], di[W:1]);
   assign unused_lsb = ^{sr[0], si[0], dr[0], di[0]};

endmodule

// File: rtl/ifft4_stream.sv
// Streaming 4-point inverse DFT. It takes bins X0..X3 in order and emits samples x0..x3 in order, scaled by 1/4.
// Latency: X3 accepted at edge E gives m_valid high after edge E+2. Collect and drain never overlap.
// Backpressure: s_ready is high only in COLLECT. While m_valid & ~m_ready, m_data/m_last/rd_idx hold.
// Ports: clk, rst (sync, active-high); s_valid/s_ready/s_data/s_last input bin stream;
//        m_valid/m_ready/m_data/m_last output sample stream; err is a one-cycle framing error pulse.

module ifft4_stream import fft_pkg::*; #(
   parameter int W = FFT_W
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           s_valid,
   output logic           s_ready,
   input  logic [2*W-1:0] s_data,
   input  logic           s_last,
   output logic           m_valid,
   input  logic           m_ready,
   output logic [2*W-1:0] m_data,
   output logic           m_last,
   output logic           err
);

   fft_state_t     state;
   logic [1:0]     wr_idx;
   logic [1:0]     rd_idx;
   logic [2*W-1:0] in_buf [4];
   logic [2*W-1:0] stg    [4];  // A0, A1, B0, B1
   logic [2*W-1:0] xr     [4];  // x0..x3
   logic [2*W-1:0] a0, a1, b0, b1;
   logic [2*W-1:0] y0, y1, y2, y3;
   logic           in_hs, out_hs;

   // Stage 1: even bins and odd bins.
   ifft_bfly2 #(.W(W)) u_s1_even (.a(in_buf[0]), .b(in_buf[2]), .rot_j(1'b0), .sum(a0), .diff(a1));
   ifft_bfly2 #(.W(W)) u_s1_odd  (.a(in_buf[1]), .b(in_buf[3]), .rot_j(1'b0), .sum(b0), .diff(b1));
   // Stage 2: the odd-index outputs take the +j twiddle on B1.
   ifft_bfly2 #(.W(W)) u_s2_even (.a(stg[0]), .b(stg[2]), .rot_j(1'b0), .sum(y0), .diff(y2));
   ifft_bfly2 #(.W(W)) u_s2_odd  (.a(stg[1]), .b(stg[3]), .rot_j(1'b1), .sum(y1), .diff(y3));

   assign s_ready = (state == COLLECT);
   assign in_hs   = s_valid & s_ready;
   assign out_hs  = m_valid & m_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= COLLECT;
         wr_idx  <= 2'd0;
         rd_idx  <= 2'd0;
         m_valid <= 1'b0;
         m_data  <= '0;
         m_last  <= 1'b0;
         err     <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            in_buf[i] <= '0;
            stg[i]    <= '0;
            xr[i]     <= '0;
         end
      end else begin
         err <= 1'b0;
         case (state)
            COLLECT: begin
               if (in_hs) begin
                  in_buf[wr_idx] <= s_data;
                  if (wr_idx == 2'd3) begin
                     // A missing s_last is flagged, but the frame is still processed.
                     state  <= S1;
                     wr_idx <= 2'd0;
                     err    <= ~s_last;
                  end else if (s_last) begin
                     // An early s_last drops the partial frame.
                     err    <= 1'b1;
                     wr_idx <= 2'd0;
                  end else begin
                     wr_idx <= wr_idx + 2'd1;
                  end
               end
            end
            S1: begin
               stg[0] <= a0;
               stg[1] <= a1;
               stg[2] <= b0;
               stg[3] <= b1;
               state  <= S2;
            end
            S2: begin
               xr[0]   <= y0;
               xr[1]   <= y1;
               xr[2]   <= y2;
               xr[3]   <= y3;
               // x0 is presented directly so m_valid rises at the same edge.
               m_valid <= 1'b1;
               m_data  <= y0;
               m_last  <= 1'b0;
               rd_idx  <= 2'd0;
               state   <= DRAIN;
            end
            DRAIN: begin
               if (out_hs) begin
                  if (rd_idx == 2'd3) begin
                     state   <= COLLECT;
                     m_valid <= 1'b0;
                     m_data  <= '0;
                     m_last  <= 1'b0;
                     rd_idx  <= 2'd0;
                  end else begin
                     rd_idx <= rd_idx + 2'd1;
                     m_data <= xr[rd_idx + 2'd1];
                     m_last <= (rd_idx == 2'd2);
                  end
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_ifft4_stream.sv
// Testbench for ifft4_stream with W=4: directed frames plus randomized frames, checked against a reference model.
// The reference computes the two-stage floor-halved inverse DFT with plain integer arithmetic.
// Ports: none (top-level bench).

`timescale 1ns/1ps
module tb_ifft4_stream;

   localparam int W = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           s_valid, s_ready, s_last;
   logic [2*W-1:0] s_data;
   logic           m_valid, m_ready, m_last, err;
   logic [2*W-1:0] m_data;

   int checks = 0;
   int errors = 0;
   int err_cnt = 0;
   int in_re[4], in_im[4];
   int exp_re[4], exp_im[4];

   ifft4_stream #(.W(W)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .err(err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (err === 1'b1) err_cnt++;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Exact floor(v/2): make v even first, then integer division is exact.
   function automatic int half(input int v);
      int m;
      m = ((v % 2) + 2) % 2;
      return (v - m) / 2;
   endfunction

   // Inverse 4-point DFT. Each radix-2 add/sub result is floor-halved.
   task automatic model();
      int a0r, a0i, a1r, a1i, b0r, b0i, b1r, b1i;
      a0r = half(in_re[0] + in_re[2]);  a0i = half(in_im[0] + in_im[2]);
      a1r = half(in_re[0] - in_re[2]);  a1i = half(in_im[0] - in_im[2]);
      b0r = half(in_re[1] + in_re[3]);  b0i = half(in_im[1] + in_im[3]);
      b1r = half(in_re[1] - in_re[3]);  b1i = half(in_im[1] - in_im[3]);
      exp_re[0] = half(a0r + b0r);      exp_im[0] = half(a0i + b0i);
      exp_re[2] = half(a0r - b0r);      exp_im[2] = half(a0i - b0i);
      // +j * B1 = (-B1.im, B1.re)
      exp_re[1] = half(a1r - b1i);      exp_im[1] = half(a1i + b1r);
      exp_re[3] = half(a1r + b1i);      exp_im[3] = half(a1i - b1r);
   endtask

   task automatic set_in(input int r0, i0, r1, i1, r2, i2, r3, i3);
      in_re[0] = r0; in_im[0] = i0; in_re[1] = r1; in_im[1] = i1;
      in_re[2] = r2; in_im[2] = i2; in_re[3] = r3; in_im[3] = i3;
   endtask

   task automatic set_exp(input int r0, i0, r1, i1, r2, i2, r3, i3);
      exp_re[0] = r0; exp_im[0] = i0; exp_re[1] = r1; exp_im[1] = i1;
      exp_re[2] = r2; exp_im[2] = i2; exp_re[3] = r3; exp_im[3] = i3;
   endtask

   // Send bins 0..nbins-1. s_last is asserted on bin last_pos (use 4 for never).
   task automatic send_bins(input int nbins, input int last_pos, input bit gaps);
      for (int i = 0; i < nbins; i++) begin
         int t;
         if (gaps) begin
            s_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
         end
         s_valid = 1'b1;
         s_data  = {in_re[i][W-1:0], in_im[i][W-1:0]};
         s_last  = (i == last_pos);
         t = 0;
         while (s_ready !== 1'b1 && t < 50) begin
            tick();
            t++;
         end
         if (s_ready !== 1'b1) check("s_ready_timeout", int'(s_ready), 1);
         tick();
         s_valid = 1'b0;
         s_last  = 1'b0;
      end
   endtask

   task automatic wait_mvalid();
      int t;
      t = 0;
      while (m_valid !== 1'b1 && t < 20) begin
         tick();
         t++;
      end
      check("m_valid_wait", int'(m_valid), 1);
   endtask

   task automatic recv_frame(input int stall_idx, input int stall_len, input bit rand_rdy);
      logic [2*W-1:0] held;
      for (int n = 0; n < 4; n++) begin
         int stalls;
         wait_mvalid();
         stalls = (n == stall_idx) ? stall_len : (rand_rdy ? int'($urandom_range(0, 2)) : 0);
         held = m_data;
         for (int k = 0; k < stalls; k++) begin
            m_ready = 1'b0;
            tick();
            check("stall_m_data", int'(m_data), int'(held));
            check("stall_m_valid", int'(m_valid), 1);
            check("stall_s_ready", int'(s_ready), 0);
         end
         m_ready = 1'b1;
         check($sformatf("x%0d_re", n), int'($signed(m_data[2*W-1:W])), exp_re[n]);
         check($sformatf("x%0d_im", n), int'($signed(m_data[W-1:0])), exp_im[n]);
         check($sformatf("x%0d_last", n), int'(m_last), (n == 3) ? 1 : 0);
         tick();
      end
      m_ready = 1'b0;
      check("m_valid_after_frame", int'(m_valid), 0);
      check("s_ready_after_frame", int'(s_ready), 1);
   endtask

   initial begin
      int e0;
      rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      check("rst_m_valid", int'(m_valid), 0);
      check("rst_m_data", int'(m_data), 0);
      check("rst_m_last", int'(m_last), 0);
      check("rst_err", int'(err), 0);
      check("rst_s_ready", int'(s_ready), 1);

      // Impulse: check latency at X3 edge E, then E+1 and E+2.
      set_in(4, 0, 0, 0, 0, 0, 0, 0);
      set_exp(1, 0, 1, 0, 1, 0, 1, 0);
      e0 = err_cnt;
      send_bins(4, 3, 1'b0);
      check("lat_e0_m_valid", int'(m_valid), 0);
      check("lat_e0_s_ready", int'(s_ready), 0);
      tick();
      check("lat_e1_m_valid", int'(m_valid), 0);
      tick();
      check("lat_e2_m_valid", int'(m_valid), 1);
      recv_frame(-1, 0, 1'b0);
      check("impulse_err", err_cnt - e0, 0);

      // Bin 1
      set_in(0, 0, 4, 0, 0, 0, 0, 0);
      set_exp(1, 0, 0, 1, -1, 0, 0, -1);
      send_bins(4, 3, 1'b0);
      recv_frame(-1, 0, 1'b0);

      // Extremes
      set_in(-8, -8, -8, -8, -8, -8, -8, -8);
      set_exp(-8, -8, 0, 0, 0, 0, 0, 0);
      send_bins(4, 3, 1'b1);
      recv_frame(-1, 0, 1'b0);
      set_in(7, 7, 7, 7, 7, 7, 7, 7);
      set_exp(7, 7, 0, 0, 0, 0, 0, 0);
      send_bins(4, 3, 1'b1);
      recv_frame(-1, 0, 1'b0);

      // Backpressure: 5-cycle stall on x1 of the bin-1 frame.
      set_in(0, 0, 4, 0, 0, 0, 0, 0);
      set_exp(1, 0, 0, 1, -1, 0, 0, -1);
      send_bins(4, 3, 1'b0);
      recv_frame(1, 5, 1'b0);

      // Early s_last on the 2nd bin: one err pulse, no output.
      set_in(3, 1, 2, 2, 0, 0, 0, 0);
      e0 = err_cnt;
      send_bins(2, 1, 1'b0);
      check("early_last_err_hi", int'(err), 1);
      tick();
      check("early_last_err_lo", int'(err), 0);
      begin
         int seen;
         seen = 0;
         for (int k = 0; k < 6; k++) begin
            if (m_valid === 1'b1) seen++;
            tick();
         end
         check("early_last_no_m_valid", seen, 0);
      end
      check("early_last_err_count", err_cnt - e0, 1);
      set_in(4, 0, 0, 0, 0, 0, 0, 0);
      set_exp(1, 0, 1, 0, 1, 0, 1, 0);
      send_bins(4, 3, 1'b0);
      recv_frame(-1, 0, 1'b0);

      // Missing s_last: the err pulse still comes, and the frame is still processed.
      set_in(-3, 5, 6, -7, 1, 2, -8, 4);
      model();
      e0 = err_cnt;
      send_bins(4, 4, 1'b0);
      recv_frame(-1, 0, 1'b0);
      check("no_last_err_count", err_cnt - e0, 1);

      // Reset mid-drain, after x0 is accepted.
      set_in(4, 0, 0, 0, 0, 0, 0, 0);
      send_bins(4, 3, 1'b0);
      wait_mvalid();
      m_ready = 1'b1;
      tick();
      rst = 1'b1;
      m_ready = 1'b0;
      tick();
      rst = 1'b0;
      check("midrst_m_valid", int'(m_valid), 0);
      check("midrst_m_data", int'(m_data), 0);
      check("midrst_m_last", int'(m_last), 0);
      check("midrst_s_ready", int'(s_ready), 1);
      set_in(0, 0, 4, 0, 0, 0, 0, 0);
      set_exp(1, 0, 0, 1, -1, 0, 0, -1);
      send_bins(4, 3, 1'b0);
      recv_frame(-1, 0, 1'b0);

      // Randomized frames against the reference model.
      for (int f = 0; f < 40; f++) begin
         int drop_last;
         for (int i = 0; i < 4; i++) begin
            in_re[i] = int'($urandom_range(0, 15)) - 8;
            in_im[i] = int'($urandom_range(0, 15)) - 8;
         end
         model();
         drop_last = ($urandom_range(0, 7) == 0) ? 1 : 0;
         e0 = err_cnt;
         send_bins(4, drop_last ? 4 : 3, 1'b1);
         recv_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1);
         check("rand_err_count", err_cnt - e0, drop_last);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
